// File: rtl/pfd_counter_mc.sv
// -----------------------------------------------------------------------------
// pfd_counter_mc
//
// Clocked, counter-based phase-frequency detector for the ADPLL. ckref and
// ckfb are synchronised into the ck domain, and their edges are detected
// according to edge_mode. The time between the leading and the lagging edge
// is counted in ck cycles. The result is reported as a signed, saturating
// phase error together with the classic up/dn pulse pair.
//
// Ports
//   ck         system clock, all logic on posedge
//   rstb       asynchronous active-low reset
//   en         synchronous enable; low aborts any comparison and idles the FSM
//   edge_mode  00 rising, 01 falling, 10 both, 11 rising
//   ckref      reference clock (asynchronous to ck)
//   ckfb       feedback clock (asynchronous to ck)
//   up         ref-leads pulse
//   dn         fb-leads pulse
//   err        signed phase error in ck cycles, positive = ref leads
//   err_valid  one-cycle strobe when err is updated
//   slip       one-cycle strobe: a second edge on the leading input arrived
//              before the closing edge
// -----------------------------------------------------------------------------
module pfd_counter_mc #(
  parameter int ERR_W       = 8,
  parameter int RST_CYC     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    ck,
  input  logic                    rstb,
  input  logic                    en,
  input  logic [1:0]              edge_mode,
  input  logic                    ckref,
  input  logic                    ckfb,
  output logic                    up,
  output logic                    dn,
  output logic signed [ERR_W-1:0] err,
  output logic                    err_valid,
  output logic                    slip
);

  // The counter is one bit narrower than err, so its all-ones value is
  // exactly the saturation magnitude 2^(ERR_W-1)-1. This means that the
  // negated count can never reach the most negative code.
  localparam int                CNT_W   = ERR_W - 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam int                RC_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RC_W-1:0]   RC_LAST = RC_W'(RST_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DN,
    S_RST
  } state_t;

  // Edge qualification for the selected polarity; 11 behaves like rising.
  function automatic logic edge_hit(input logic cur, input logic prev,
                                    input logic [1:0] mode);
    case (mode)
      2'b01:   return ~cur & prev;
      2'b10:   return cur ^ prev;
      default: return cur & ~prev;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sync_ref, sync_fb;
  logic                   s_ref, s_fb;
  logic                   ref_d, fb_d;
  logic                   ref_edge, fb_edge;
  logic                   e_ref, e_fb;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n, cnt_inc;
  logic [RC_W-1:0]        rc, rc_n;
  logic                   pend_ref, pend_ref_n;
  logic                   pend_fb, pend_fb_n;
  logic                   up_n, dn_n, err_valid_n, slip_n;
  logic signed [ERR_W-1:0] err_n;

  assign s_ref = sync_ref[SYNC_STAGES-1];
  assign s_fb  = sync_fb[SYNC_STAGES-1];

  // History always follows the synchronised level. Therefore, a change of
  // edge_mode only reinterprets the current pair and never invents an edge.
  assign ref_edge = edge_hit(s_ref, ref_d, edge_mode);
  assign fb_edge  = edge_hit(s_fb,  fb_d,  edge_mode);

  // Edges that arrived during the self-reset pulse are merged in here.
  assign e_ref = ref_edge | pend_ref;
  assign e_fb  = fb_edge  | pend_fb;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // NOTE: every flop, including the synchroniser chains, is reset. The chains
  // are only a few bits wide, and a known history prevents a phantom edge
  // from appearing on the first cycle after reset.
  always_ff @(posedge ck or negedge rstb) begin
    if (!rstb) begin
      sync_ref  <= '0;
      sync_fb   <= '0;
      ref_d     <= 1'b0;
      fb_d      <= 1'b0;
      state     <= S_IDLE;
      cnt       <= '0;
      rc        <= '0;
      pend_ref  <= 1'b0;
      pend_fb   <= 1'b0;
      up        <= 1'b0;
      dn        <= 1'b0;
      err       <= '0;
      err_valid <= 1'b0;
      slip      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, so the shift chain advances one stage per clock.
      sync_ref  <= {sync_ref[SYNC_STAGES-2:0], ckref};
      sync_fb   <= {sync_fb[SYNC_STAGES-2:0], ckfb};
      ref_d     <= s_ref;
      fb_d      <= s_fb;
      state     <= state_n;
      cnt       <= cnt_n;
      rc        <= rc_n;
      pend_ref  <= pend_ref_n;
      pend_fb   <= pend_fb_n;
      up        <= up_n;
      dn        <= dn_n;
      err       <= err_n;
      err_valid <= err_valid_n;
      slip      <= slip_n;
    end
  end

  always_comb begin
    // NOTE: each output of this block gets a default value first. As a
    // result, no path through the case statement can infer a latch.
    state_n     = state;
    cnt_n       = cnt;
    rc_n        = rc;
    pend_ref_n  = pend_ref;
    pend_fb_n   = pend_fb;
    up_n        = up;
    dn_n        = dn;
    err_n       = err;
    err_valid_n = 1'b0;
    slip_n      = 1'b0;

    if (!en) begin
      state_n    = S_IDLE;
      cnt_n      = '0;
      rc_n       = '0;
      pend_ref_n = 1'b0;
      pend_fb_n  = 1'b0;
      up_n       = 1'b0;
      dn_n       = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          pend_ref_n = 1'b0;
          pend_fb_n  = 1'b0;
          if (e_ref && e_fb) begin
            up_n        = 1'b1;
            dn_n        = 1'b1;
            err_n       = '0;
            err_valid_n = 1'b1;
            rc_n        = '0;
            state_n     = S_RST;
          end else if (e_ref) begin
            up_n    = 1'b1;
            cnt_n   = CNT_W'(1);
            state_n = S_UP;
          end else if (e_fb) begin
            dn_n    = 1'b1;
            cnt_n   = CNT_W'(1);
            state_n = S_DN;
          end
        end

        S_UP: begin
          // A repeated leading edge is flagged even when it coincides with
          // the closing edge.
          slip_n = ref_edge;
          if (fb_edge) begin
            err_n       = $signed({1'b0, cnt});
            err_valid_n = 1'b1;
            dn_n        = 1'b1;
            rc_n        = '0;
            state_n     = S_RST;
          end else begin
            cnt_n = cnt_inc;
          end
        end

        S_DN: begin
          slip_n = fb_edge;
          if (ref_edge) begin
            err_n       = -$signed({1'b0, cnt});
            err_valid_n = 1'b1;
            up_n        = 1'b1;
            rc_n        = '0;
            state_n     = S_RST;
          end else begin
            cnt_n = cnt_inc;
          end
        end

        S_RST: begin
          pend_ref_n = pend_ref | ref_edge;
          pend_fb_n  = pend_fb  | fb_edge;
          if (rc == RC_LAST) begin
            up_n    = 1'b0;
            dn_n    = 1'b0;
            cnt_n   = '0;
            rc_n    = '0;
            state_n = S_IDLE;
          end else begin
            rc_n = rc + RC_W'(1);
          end
        end

        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pfd_counter_mc.md
Name: pfd_counter_mc

Overview:
- Clocked, counter-based phase-frequency detector: successor to the event-driven analog PFD model.
- Samples ckref/ckfb with system clock ck, produces up/dn pulses and a signed digital phase error in ck cycles.
- Edge polarity is selectable, reset-pulse width is parametrised, and cycle slips are flagged.
- Sits between divider outputs and the digital loop filter of the ADPLL.

Parameters:
- ERR_W, 8, width of signed error output err; magnitude saturates at 2^(ERR_W-1)-1.
- RST_CYC, 2, ck cycles up and dn are held together after a phase comparison (self-reset pulse width); legal range >=1.
- SYNC_STAGES, 2, synchroniser flops on each of ckref and ckfb; legal range >=2.

Ports:
- ck  input  1  system clock; all logic on posedge.
- rstb  input  1  reset, asynchronous, active low.
- en  input  1  synchronous enable; low forces IDLE.
- edge_mode  input  2  00 rising, 01 falling, 10 both, 11 rising.
- ckref  input  1  reference clock, asynchronous to ck.
- ckfb  input  1  feedback clock, asynchronous to ck.
- up  output  1  ref-leads pulse.
- dn  output  1  fb-leads pulse.
- err  output  ERR_W  signed phase error in ck cycles; positive means ref leads.
- err_valid  output  1  one-cycle strobe, err updated.
- slip  output  1  one-cycle strobe, second edge on the leading input before closing edge.

Behaviour:
- Reset (rstb low, async): up=dn=0, err=0, err_valid=0, slip=0, state=IDLE, cnt=0, pending flags=0, sync chains=0, edge history=0.
- Sync: each input passes through SYNC_STAGES flops to give s_ref/s_fb. Edge detect compares s_x with its 1-cycle-delayed copy per edge_mode. History registers always update, so an edge_mode change never creates a spurious edge.
- Latency: pin transition to up/dn rise = SYNC_STAGES+1 ck edges.
- States: IDLE, UP, DN, RST. Define e_ref = ref edge OR pend_ref, and e_fb likewise.
- IDLE, e_ref & e_fb in the same cycle: next cycle up=dn=1, err=0, err_valid=1, enter RST.
- IDLE, e_ref only: next cycle up=1, cnt=1, enter UP.
- IDLE, e_fb only: next cycle dn=1, cnt=1, enter DN.
- In IDLE, pending flags clear once consumed.
- UP, no fb edge: cnt+=1 per cycle, saturating at 2^(ERR_W-1)-1.
- UP, extra ref edge: slip=1 next cycle. cnt is not restarted. Simultaneous extra ref edge and fb edge: closing takes precedence and also pulses slip.
- UP, fb edge while cnt=c: next cycle err=+c, err_valid=1, dn=1, up stays 1, enter RST.
- DN mirrors UP: err=-c, saturating at -(2^(ERR_W-1)-1). err never takes the most negative code.
- RST: up=dn=1 for exactly RST_CYC cycles, then up=dn=0, cnt=0, return to IDLE.
- Edges arriving during RST set pend_ref/pend_fb (one level each, further edges merge) and are processed in the first IDLE cycle.
- err holds its value between strobes. err_valid and slip are single-cycle pulses.
- en low: next cycle state=IDLE, up=dn=0, cnt=0, pending cleared. No err_valid/slip. err holds its value. Sync and history registers keep running.
- en rising: only edges detected after that cycle count.
- rstb asserted mid-UP/DN/RST: immediate clear as above. No err_valid is produced for the aborted comparison.

Test Plan:
- RST_CYC=2, rising mode: ref edge then fb edge 5 ck cycles later -> err=+5 with 1-cycle err_valid; up high 7 cycles; dn high last 2 cycles; then IDLE.
- fb leads ref by 3 cycles -> err=-3; dn high 5 cycles; up high last 2.
- ref and fb synchronised in the same cycle -> err=0, err_valid=1, up=dn=1 for exactly 2 cycles.
- ERR_W=8, fb lags 200 cycles -> err=+127 (saturated); no wrap; slip=0.
- Two ref edges 10 cycles apart, then fb 15 cycles after the first ref edge -> slip pulse 1 cycle after the 2nd ref edge; err=+15.
- edge_mode=01 with only falling edges offset by 4 -> err=+4, and rising edges are ignored.
- fb edge during RST -> processed on IDLE entry, opening a DN comparison.
- rstb pulsed low mid-UP -> up=0 immediately, no err_valid.
